pll_cfg_sequencer: RTL and testbench

PLL_CFG_SEQUENCER -- requirements
Module: pll_cfg_sequencer

---
 rtl/pll_pkg.sv | 37 +++
 rtl/ahb_single_master.sv | 87 ++++++++
 rtl/pll_cfg_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL configuration sequencer and its AHB-Lite master.
package pll_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_BYP, S_CFG, S_EN, S_POLL, S_GAP, S_RUN, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_HRESP   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  typedef enum logic [1:0] {
    PH_IDLE, PH_ADDR, PH_DATA
  } phase_t;

  localparam logic [ADDR_W-1:0] OFS_CTRL = 32'h0;
  localparam logic [ADDR_W-1:0] OFS_EN   = 32'h4;
  localparam logic [ADDR_W-1:0] OFS_STAT = 32'h8;
  localparam logic [ADDR_W-1:0] OFS_CFG  = 32'hC;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ahb_req_t;

endpackage

// File: rtl/ahb_single_master.sv
// One AHB-Lite single transfer at a time: NONSEQ address phase, then a data phase stretched by hready.
module ahb_single_master
  import pll_pkg::*;
(
  input  logic              i_clk_ahb,
  input  logic              i_rst_ahb,
  input  logic              start_c,
  input  ahb_req_t          req_c,
  output logic [1:0]        htrans,
  output logic              hsel,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic              done_c,
  output logic              err_c,
  output logic [DATA_W-1:0] rdata_c
);

  phase_t            phase, phase_d;
  logic [1:0]        htrans_d;
  logic              hsel_d, hwrite_d;
  logic [ADDR_W-1:0] haddr_d;
  logic [DATA_W-1:0] hwdata_d, wdata_q, wdata_d;

  assign rdata_c = hrdata;

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      phase   <= PH_IDLE;
      htrans  <= HTRANS_IDLE;
      hsel    <= 1'b0;
      hwrite  <= 1'b0;
      haddr   <= '0;
      hwdata  <= '0;
      wdata_q <= '0;
    end else begin
      phase   <= phase_d;
      htrans  <= htrans_d;
      hsel    <= hsel_d;
      hwrite  <= hwrite_d;
      haddr   <= haddr_d;
      hwdata  <= hwdata_d;
      wdata_q <= wdata_d;
    end
  end

  // Address and write enable stay put after the address phase; write data moves onto the bus for the data phase.
  always_comb begin
    phase_d  = phase;
    htrans_d = HTRANS_IDLE;
    hsel_d   = 1'b0;
    hwrite_d = hwrite;
    haddr_d  = haddr;
    hwdata_d = hwdata;
    wdata_d  = wdata_q;
    done_c   = 1'b0;
    err_c    = 1'b0;
    case (phase)
      PH_ADDR: begin
        phase_d  = PH_DATA;
        hwdata_d = wdata_q;
      end
      PH_DATA: begin
        if (hresp) begin
          err_c   = 1'b1;
          phase_d = PH_IDLE;
        end else if (hready) begin
          done_c  = 1'b1;
          phase_d = PH_IDLE;
        end
      end
      default: ;
    endcase
    if (start_c) begin
      phase_d  = PH_ADDR;
      htrans_d = HTRANS_NONSEQ;
      hsel_d   = 1'b1;
      hwrite_d = req_c.write;
      haddr_d  = req_c.addr;
      wdata_d  = req_c.wdata;
    end
  end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Reprograms a PLL over AHB-Lite: bypass, load multiplier/divider, enable, poll for lock, leave bypass.
module pll_cfg_sequencer
  import pll_pkg::*;
#(
  parameter logic [31:0] PLL_BASE     = 32'h0000_0000,
  parameter int unsigned LOCK_TIMEOUT = 1023,
  parameter int unsigned POLL_GAP     = 4
) (
  input  logic        i_clk_ahb,
  input  logic        i_rst_ahb,
  input  logic        i_req,
  input  logic [23:0] i_mult,
  input  logic [7:0]  i_div,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [1:0]  o_htrans,
  output logic        o_hsel,
  output logic        o_hwrite,
  output logic [2:0]  o_hsize,
  output logic [2:0]  o_hburst,
  output logic [31:0] o_haddr,
  output logic [31:0] o_hwdata,
  input  logic        i_hready,
  input  logic        i_hresp,
  input  logic [31:0] i_hrdata
);

  localparam int unsigned CNT_W = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  state_t           state, state_d;
  logic [23:0]      mult_q, mult_d;
  logic [7:0]       div_q, div_d;
  logic [CNT_W-1:0] poll_cnt, poll_d, poll_inc;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  err_code_t        code_q, code_d;
  logic             busy_d, done_d, err_d;
  logic             start_c, xfer_done_c, xfer_err_c;
  ahb_req_t         req_c;
  logic [31:0]      rdata_c;
  logic             unused_rdata;

  assign o_hsize      = HSIZE_WORD;
  assign o_hburst     = HBURST_SINGLE;
  assign o_err_code   = code_q;
  assign unused_rdata = ^rdata_c[31:1];

  ahb_single_master u_master (
    .i_clk_ahb (i_clk_ahb),
    .i_rst_ahb (i_rst_ahb),
    .start_c   (start_c),
    .req_c     (req_c),
    .htrans    (o_htrans),
    .hsel      (o_hsel),
    .hwrite    (o_hwrite),
    .haddr     (o_haddr),
    .hwdata    (o_hwdata),
    .hready    (i_hready),
    .hresp     (i_hresp),
    .hrdata    (i_hrdata),
    .done_c    (xfer_done_c),
    .err_c     (xfer_err_c),
    .rdata_c   (rdata_c)
  );

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state    <= S_IDLE;
      mult_q   <= '0;
      div_q    <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      code_q   <= ERR_NONE;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_d;
      mult_q   <= mult_d;
      div_q    <= div_d;
      poll_cnt <= poll_d;
      gap_cnt  <= gap_d;
      code_q   <= code_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_err    <= err_d;
    end
  end

  // Each transfer is launched on the edge that enters its state, so a zero-wait transfer costs two cycles.
  always_comb begin
    state_d  = state;
    mult_d   = mult_q;
    div_d    = div_q;
    poll_d   = poll_cnt;
    gap_d    = gap_cnt;
    code_d   = code_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    start_c  = 1'b0;
    req_c    = '0;
    poll_inc = (poll_cnt == CNT_MAX) ? poll_cnt : poll_cnt + CNT_W'(1);

    case (state)
      S_IDLE: if (i_req) begin
        mult_d  = i_mult;
        div_d   = i_div;
        code_d  = ERR_NONE;
        poll_d  = '0;
        gap_d   = '0;
        state_d = S_BYP;
        start_c = 1'b1;
      end
      S_BYP:  if (xfer_done_c) begin state_d = S_CFG;  start_c = 1'b1; end
      S_CFG:  if (xfer_done_c) begin state_d = S_EN;   start_c = 1'b1; end
      S_EN:   if (xfer_done_c) begin state_d = S_POLL; start_c = 1'b1; end
      S_POLL: if (xfer_done_c) begin
        if (rdata_c[0]) begin
          state_d = S_RUN;
          start_c = 1'b1;
        end else begin
          poll_d = poll_inc;
          if (poll_inc == CNT_MAX) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_IDLE;
          end else if (POLL_GAP == 0) begin
            start_c = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = S_POLL;
          start_c = 1'b1;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      S_RUN:  if (xfer_done_c) begin state_d = S_FIN; done_d = 1'b1; end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A slave error aborts wherever it occurs; the PLL is left as the last good write put it.
    if (xfer_err_c) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_HRESP;
      start_c = 1'b0;
    end

    case (state_d)
      S_BYP:  begin req_c.write = 1'b1; req_c.addr = PLL_BASE + OFS_CTRL; req_c.wdata = 32'h1; end
      S_CFG:  begin req_c.write = 1'b1; req_c.addr = PLL_BASE + OFS_CFG;  req_c.wdata = {mult_d, div_d}; end
      S_EN:   begin req_c.write = 1'b1; req_c.addr = PLL_BASE + OFS_EN;   req_c.wdata = 32'h1; end
      S_POLL: begin req_c.write = 1'b0; req_c.addr = PLL_BASE + OFS_STAT; end
      S_RUN:  begin req_c.write = 1'b1; req_c.addr = PLL_BASE + OFS_CTRL; req_c.wdata = 32'h0; end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
  end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed bench for pll_cfg_sequencer against a small AHB-Lite slave model with configurable waits, errors and lock.
`timescale 1ns/1ps
module tb_pll_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [23:0] mult = '0;
  logic [7:0]  div = '0;
  logic        busy, done, err, hsel, hwrite, hready, hresp;
  logic [1:0]  code, htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata, hrdata;

  always #5 clk = ~clk;

  pll_cfg_sequencer #(.PLL_BASE(32'h0), .LOCK_TIMEOUT(8), .POLL_GAP(4)) dut (
    .i_clk_ahb(clk), .i_rst_ahb(rst), .i_req(req), .i_mult(mult), .i_div(div),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(code),
    .o_htrans(htrans), .o_hsel(hsel), .o_hwrite(hwrite), .o_hsize(hsize), .o_hburst(hburst),
    .o_haddr(haddr), .o_hwdata(hwdata), .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
  );

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  // slave configuration, written only by the test tasks
  logic [31:0] wait_addr = 32'hFFFF_FFFF;
  int          wait_n = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          lock_read_n = 1;

  // slave / monitor state, written only by the slave process
  int          cyc = 0;
  logic        dp_active = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr = '0;
  int          dp_wait = 0, dp_age = 0, dp_ap = 0, rd_n = 0;
  logic [31:0] prev_haddr = '0, prev_hwdata = '0;
  int          log_n = 0;
  logic        log_w [128];
  logic [31:0] log_a [128];
  logic [31:0] log_d [128];
  int          log_ap [128];
  int          log_end [128];
  int          ap_total = 0, ap_viol = 0, hold_viol = 0;
  int          done_pulses = 0, err_pulses = 0, both_viol = 0, busy_viol = 0;

  assign hresp  = dp_active && dp_write && (dp_addr == err_addr);
  assign hready = !(dp_active && ((dp_wait > 0) || hresp));
  assign hrdata = (dp_active && !dp_write && dp_addr == 32'h8 && lock_read_n != 0 && rd_n + 1 == lock_read_n)
                  ? 32'hA5A5_0001 : 32'hA5A5_0000;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    prev_haddr  <= haddr;
    prev_hwdata <= hwdata;
    if (done && err) both_viol <= both_viol + 1;
    if ((done || err) && busy) busy_viol <= busy_viol + 1;
    if (done) done_pulses <= done_pulses + 1;
    if (err) err_pulses <= err_pulses + 1;
    if (req && !busy) rd_n <= 0;
    if (rst) begin
      dp_active <= 1'b0;
    end else begin
      if (dp_active) begin
        if (dp_age > 0 && dp_write && (haddr != prev_haddr || hwdata != prev_hwdata)) hold_viol <= hold_viol + 1;
        dp_age <= dp_age + 1;
        if (hresp) begin
          dp_active <= 1'b0;
        end else if (hready) begin
          dp_active      <= 1'b0;
          log_w[log_n]   <= dp_write;
          log_a[log_n]   <= dp_addr;
          log_d[log_n]   <= dp_write ? hwdata : hrdata;
          log_ap[log_n]  <= dp_ap;
          log_end[log_n] <= cyc;
          log_n          <= log_n + 1;
          if (!dp_write && dp_addr == 32'h8) rd_n <= rd_n + 1;
        end else if (dp_wait > 0) begin
          dp_wait <= dp_wait - 1;
        end
      end
      if (htrans == 2'b10 && hsel) begin
        ap_total  <= ap_total + 1;
        if (dp_active && !hready) ap_viol <= ap_viol + 1;
        dp_active <= 1'b1;
        dp_write  <= hwrite;
        dp_addr   <= haddr;
        dp_age    <= 0;
        dp_ap     <= cyc;
        dp_wait   <= (haddr == wait_addr) ? wait_n : 0;
      end
    end
  end

  task automatic start_req(input logic [23:0] m, input logic [7:0] d);
    mult = m; div = d; req = 1'b1; acc_cyc = cyc;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int lat, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done || err) begin to = 1'b0; break; end
      @(posedge clk); #1;
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++;
      $display("FAIL reset_status busy/done/err=%b%b%b expected 000", busy, done, err); end
    checks++; if (code !== 2'd0) begin errors++; $display("FAIL reset_code got %0d expected 0", code); end
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0 || hwrite !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl htrans=%b hsel=%b hwrite=%b expected 00 0 0", htrans, hsel, hwrite); end
    checks++; if (haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr got %h expected 0", haddr); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata got %h expected 0", hwdata); end
    checks++; if (hsize !== 3'b010) begin errors++; $display("FAIL hsize got %b expected 010", hsize); end
    checks++; if (hburst !== 3'b000) begin errors++; $display("FAIL hburst got %b expected 000", hburst); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int base, d0, e0, lat;
    bit to;
    logic        ew [5];
    logic [31:0] ea [5];
    logic [31:0] ed [5];
    ew = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ea = '{32'h0, 32'hC, 32'h4, 32'h8, 32'h0};
    ed = '{32'h1, 32'h0000_030B, 32'h1, 32'h0, 32'h0};
    base = log_n; d0 = done_pulses; e0 = err_pulses;
    lock_read_n = 1;
    start_req(24'h3, 8'h0B);
    checks++; if (busy !== 1'b1 || htrans !== 2'b10 || hsel !== 1'b1) begin errors++;
      $display("FAIL basic_first_addr busy=%b htrans=%b hsel=%b expected 1 10 1", busy, htrans, hsel); end
    wait_end(100, lat, to);
    checks++; if (to || lat != 11) begin errors++; $display("FAIL basic_latency got %0d timeout=%0d expected 11", lat, to); end
    checks++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL basic_end done/err/busy=%b%b%b expected 100", done, err, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || done_pulses - d0 != 1 || err_pulses != e0) begin errors++;
      $display("FAIL basic_pulse done=%b pulses=%0d errs=%0d expected 0 1 0", done, done_pulses - d0, err_pulses - e0); end
    checks++; if (log_n - base != 5) begin errors++; $display("FAIL basic_count got %0d expected 5", log_n - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_w[base+i] !== ew[i] || log_a[base+i] !== ea[i] || (ew[i] && log_d[base+i] !== ed[i]) ||
          log_end[base+i] - log_ap[base+i] != 1) begin
        errors++;
        $display("FAIL basic_xfer%0d got w=%b a=%h d=%h len=%0d expected w=%b a=%h d=%h len=1", i,
                 log_w[base+i], log_a[base+i], log_d[base+i], log_end[base+i] - log_ap[base+i], ew[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int base, lat;
    bit to;
    base = log_n;
    wait_addr = 32'hC; wait_n = 2; lock_read_n = 1;
    start_req(24'h3, 8'h0B);
    wait_end(100, lat, to);
    checks++; if (to || lat != 13 || done !== 1'b1) begin errors++;
      $display("FAIL wait_latency got %0d done=%b expected 13 1", lat, done); end
    @(posedge clk); #1;
    wait_addr = 32'hFFFF_FFFF; wait_n = 0;
    checks++; if (log_n - base != 5 || log_a[base+1] !== 32'hC || log_d[base+1] !== 32'h0000_030B) begin errors++;
      $display("FAIL wait_cfg count=%0d a=%h d=%h expected 5 c 0000030b", log_n - base, log_a[base+1], log_d[base+1]); end
    checks++; if (log_end[base+1] - log_ap[base+1] != 3) begin errors++;
      $display("FAIL wait_len got %0d expected 3", log_end[base+1] - log_ap[base+1]); end
  endtask

  task automatic test_poll_gap();
    int base, lat;
    bit to;
    logic [31:0] ea [7];
    ea = '{32'h0, 32'hC, 32'h4, 32'h8, 32'h8, 32'h8, 32'h0};
    base = log_n;
    lock_read_n = 3;
    start_req(24'h50, 8'h02);
    wait_end(200, lat, to);
    checks++; if (to || lat != 23 || done !== 1'b1) begin errors++;
      $display("FAIL poll_latency got %0d done=%b expected 23 1", lat, done); end
    @(posedge clk); #1;
    checks++; if (log_n - base != 7) begin errors++; $display("FAIL poll_count got %0d expected 7", log_n - base); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (log_a[base+i] !== ea[i]) begin errors++;
        $display("FAIL poll_addr%0d got %h expected %h", i, log_a[base+i], ea[i]); end
    end
    checks++; if (log_d[base+1] !== 32'h0000_5002 || log_w[base+6] !== 1'b1 || log_d[base+6] !== 32'h0) begin errors++;
      $display("FAIL poll_data cfg=%h run_w=%b run_d=%h expected 00005002 1 0", log_d[base+1], log_w[base+6], log_d[base+6]); end
    for (int i = 4; i < 6; i++) begin
      checks++; if (log_ap[base+i] - log_end[base+i-1] != 5) begin errors++;
        $display("FAIL poll_gap%0d got %0d expected 5", i, log_ap[base+i] - log_end[base+i-1]); end
    end
    checks++; if (log_ap[base+6] - log_end[base+5] != 1) begin errors++;
      $display("FAIL poll_run_gap got %0d expected 1", log_ap[base+6] - log_end[base+5]); end
  endtask

  task automatic test_timeout();
    int base, d0, lat;
    bit to;
    base = log_n; d0 = done_pulses;
    lock_read_n = 0;
    start_req(24'hABCDEF, 8'h01);
    wait_end(300, lat, to);
    checks++; if (to || lat != 51) begin errors++; $display("FAIL timeout_latency got %0d timeout=%0d expected 51", lat, to); end
    checks++; if (err !== 1'b1 || done !== 1'b0 || code !== 2'd2 || busy !== 1'b0) begin errors++;
      $display("FAIL timeout_flags err=%b done=%b code=%0d busy=%b expected 1 0 2 0", err, done, code, busy); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (log_n - base != 11 || log_d[base+1] !== 32'hABCD_EF01) begin errors++;
      $display("FAIL timeout_count got %0d cfg=%h expected 11 abcdef01", log_n - base, log_d[base+1]); end
    for (int i = 3; i < 11; i++) begin
      checks++; if (log_w[base+i] !== 1'b0 || log_a[base+i] !== 32'h8) begin errors++;
        $display("FAIL timeout_read%0d got w=%b a=%h expected 0 8", i, log_w[base+i], log_a[base+i]); end
    end
    checks++; if (code !== 2'd2 || err !== 1'b0 || done_pulses != d0) begin errors++;
      $display("FAIL timeout_hold code=%0d err=%b done_pulses=%0d expected 2 0 0", code, err, done_pulses - d0); end
  endtask

  task automatic test_hresp_ignore_req();
    int base, ap0, lat;
    bit to;
    base = log_n; ap0 = ap_total;
    err_addr = 32'h4; lock_read_n = 1;
    start_req(24'h123456, 8'h78);
    mult = 24'hFFFFFF; div = 8'hFF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_end(100, lat, to);
    checks++; if (to || lat != 7 || err !== 1'b1 || code !== 2'd1 || done !== 1'b0) begin errors++;
      $display("FAIL hresp_abort lat=%0d err=%b code=%0d done=%b expected 7 1 1 0", lat, err, code, done); end
    repeat (10) @(posedge clk);
    #1;
    err_addr = 32'hFFFF_FFFF;
    checks++; if (ap_total - ap0 != 3 || htrans !== 2'b00 || hsel !== 1'b0) begin errors++;
      $display("FAIL hresp_no_more_xfers got %0d htrans=%b expected 3 00", ap_total - ap0, htrans); end
    checks++; if (log_n - base != 2 || log_d[base+1] !== 32'h1234_5678) begin errors++;
      $display("FAIL hresp_ignored_req count=%0d cfg=%h expected 2 12345678", log_n - base, log_d[base+1]); end
    checks++; if (code !== 2'd1) begin errors++; $display("FAIL hresp_code_hold got %0d expected 1", code); end
  endtask

  task automatic test_reset_mid_poll();
    int e0, d0, lat;
    bit to, found;
    e0 = err_pulses; d0 = done_pulses;
    lock_read_n = 0;
    start_req(24'h1, 8'h01);
    checks++; if (code !== 2'd0 || busy !== 1'b1) begin errors++;
      $display("FAIL accept_clears_code code=%0d busy=%b expected 0 1", code, busy); end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (htrans == 2'b10 && haddr == 32'h8) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_poll got no STAT read expected one"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (htrans !== 2'b00 || hsel !== 1'b0 || hwrite !== 1'b0 || haddr !== 32'h0 || hwdata !== 32'h0) begin errors++;
      $display("FAIL rstmid_bus htrans=%b hsel=%b hwrite=%b haddr=%h hwdata=%h expected all 0", htrans, hsel, hwrite, haddr, hwdata); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || code !== 2'd0) begin errors++;
      $display("FAIL rstmid_status busy=%b done=%b err=%b code=%0d expected 0 0 0 0", busy, done, err, code); end
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++; if (busy !== 1'b0 || htrans !== 2'b00) begin errors++;
      $display("FAIL rstmid_held busy=%b htrans=%b expected 0 00", busy, htrans); end
    lock_read_n = 1;
    #2 rst = 1'b0;
    start_req(24'h3, 8'h0B);
    checks++; if (busy !== 1'b1 || htrans !== 2'b10 || haddr !== 32'h0) begin errors++;
      $display("FAIL rstmid_accept busy=%b htrans=%b haddr=%h expected 1 10 0", busy, htrans, haddr); end
    wait_end(100, lat, to);
    checks++; if (to || lat != 11 || done !== 1'b1) begin errors++;
      $display("FAIL rstmid_restart lat=%0d done=%b expected 11 1", lat, done); end
    @(posedge clk); #1;
    checks++; if (err_pulses != e0 || done_pulses - d0 != 1) begin errors++;
      $display("FAIL rstmid_pulses err=%0d done=%0d expected 0 1", err_pulses - e0, done_pulses - d0); end
  endtask

  task automatic test_protocol();
    checks++; if (both_viol != 0) begin errors++; $display("FAIL done_err_overlap got %0d expected 0", both_viol); end
    checks++; if (busy_viol != 0) begin errors++; $display("FAIL busy_at_pulse got %0d expected 0", busy_viol); end
    checks++; if (ap_viol != 0) begin errors++; $display("FAIL addr_during_stall got %0d expected 0", ap_viol); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL stall_hold got %0d expected 0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_poll_gap();
    test_timeout();
    test_hresp_ignore_req();
    test_reset_mid_poll();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish by 100us");
    $fatal(1);
  end

endmodule
